// File: rtl/matrix_result_sender_if.sv
// Bus bundle between the result framer, the result memory read port,
// the frame controller (start/busy/done) and uart_tx.
//   start     frame request pulse
//   res_addr  result memory read address (synchronous read)
//   res_data  result memory read data, valid one cycle after res_addr
//   tx_data   byte presented to uart_tx
//   tx_start  one-cycle transmit request to uart_tx
//   tx_busy   uart_tx busy flag
//   busy      framer is working on a frame
//   done      one-cycle end-of-frame pulse
// master = the framer's view, slave = everything around it.
interface matrix_result_sender_if #(
  parameter int ADDR_W = 4,
  parameter int RES_W  = 16
);
  logic              start;
  logic [ADDR_W-1:0] res_addr;
  logic [RES_W-1:0]  res_data;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              busy;
  logic              done;

  modport master (
    input  start, res_data, tx_busy,
    output res_addr, tx_data, tx_start, busy, done
  );

  modport slave (
    output start, res_data, tx_busy,
    input  res_addr, tx_data, tx_start, busy, done
  );
endinterface

// File: rtl/matrix_result_sender.sv
// Transmit-side framer for the matrix-multiplication result.
// Reads the N*N result matrix row-major from result memory, splits each
// entry into bytes (MSB first) and sends
//   HEADER, data bytes..., XOR of data bytes
// one byte at a time through uart_tx's start/busy handshake.
// Ports:
//   clk   system clock (shared with uart_tx)
//   rst   asynchronous, active-high reset; aborts a frame immediately
//   bus   matrix_result_sender_if.master (start, res_addr, res_data,
//         tx_data, tx_start, tx_busy, busy, done)
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start
// S_HDR     | load header byte into tx_data
// S_FETCH   | res_addr holds the current entry; memory read in flight
// S_CAPTURE | latch res_data into the shift register
// S_LOAD    | present the next entry byte, fold it into the checksum
// S_SEND    | wait for uart_tx idle, then pulse tx_start
// S_ACK     | wait for uart_tx to take the byte (tx_busy rises)
// S_DRAIN   | wait for the byte to finish (tx_busy falls), then advance
// S_DONE    | one-cycle done pulse
module matrix_result_sender #(
  parameter int         N      = 3,
  parameter int         RES_W  = 16,
  parameter int         ADDR_W = 4,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  matrix_result_sender_if.master bus
);

  localparam int BYTES = RES_W / 8;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int NN    = N * N;

  localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(NN - 1);
  localparam logic [BI_W-1:0]   LAST_BYTE  = BI_W'(BYTES - 1);

  if ((RES_W % 8) != 0 || RES_W < 8) begin : g_bad_res_w
    $error("RES_W must be a positive multiple of 8");
  end
  if ((2 ** ADDR_W) < NN) begin : g_bad_addr_w
    $error("ADDR_W too small for N*N entries");
  end

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_CAPTURE,
    S_LOAD,
    S_SEND,
    S_ACK,
    S_DRAIN,
    S_DONE
  } state_t;

  // What the byte currently in flight is; decides where DRAIN goes next.
  typedef enum logic [1:0] {
    K_HDR,
    K_DATA,
    K_CSUM
  } kind_t;

  state_t             state, state_nxt;
  kind_t              kind;
  logic [ADDR_W-1:0]  entry;
  logic [BI_W-1:0]    byte_idx;
  logic [RES_W-1:0]   shreg;
  logic [7:0]         checksum;
  logic [7:0]         cur_byte;

  // Byte byte_idx of the latched entry always sits at the top of the
  // shift register, because DRAIN shifts left by one byte per data byte.
  assign cur_byte = shreg[RES_W-1 -: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // tx_start, busy and done are decoded from state so that an asynchronous
  // reset drops them in the same cycle without waiting for a clock edge.
  always_comb begin
    state_nxt    = state;
    bus.tx_start = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = S_HDR;
      end
      S_HDR: begin
        bus.busy  = 1'b1;
        state_nxt = S_SEND;
      end
      S_FETCH: begin
        bus.busy  = 1'b1;
        state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        bus.busy  = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        bus.busy  = 1'b1;
        state_nxt = S_SEND;
      end
      S_SEND: begin
        bus.busy = 1'b1;
        if (!bus.tx_busy) begin
          bus.tx_start = 1'b1;
          state_nxt    = S_ACK;
        end
      end
      S_ACK: begin
        bus.busy = 1'b1;
        if (bus.tx_busy) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        bus.busy = 1'b1;
        if (!bus.tx_busy) begin
          case (kind)
            K_HDR:  state_nxt = S_FETCH;
            K_DATA: begin
              if (byte_idx != LAST_BYTE)   state_nxt = S_LOAD;
              else if (entry != LAST_ENTRY) state_nxt = S_FETCH;
              else                          state_nxt = S_SEND;
            end
            K_CSUM:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
          endcase
        end
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.res_addr <= '0;
      bus.tx_data  <= '0;
      kind         <= K_HDR;
      entry        <= '0;
      byte_idx     <= '0;
      shreg        <= '0;
      checksum     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) checksum <= '0;
        end
        S_HDR: begin
          bus.tx_data <= HEADER;
          kind        <= K_HDR;
        end
        S_CAPTURE: begin
          shreg    <= bus.res_data;
          byte_idx <= '0;
        end
        S_LOAD: begin
          bus.tx_data <= cur_byte;
          checksum    <= checksum ^ cur_byte;
        end
        S_DRAIN: begin
          if (!bus.tx_busy) begin
            case (kind)
              K_HDR: begin
                entry        <= '0;
                bus.res_addr <= '0;
                kind         <= K_DATA;
              end
              K_DATA: begin
                if (byte_idx != LAST_BYTE) begin
                  byte_idx <= byte_idx + BI_W'(1);
                  shreg    <= shreg << 8;
                end else if (entry != LAST_ENTRY) begin
                  entry        <= entry + ADDR_W'(1);
                  bus.res_addr <= entry + ADDR_W'(1);
                end else begin
                  // Checksum already includes the last data byte (folded in LOAD).
                  bus.tx_data <= checksum;
                  kind        <= K_CSUM;
                end
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_sender.sv
module tb_matrix_result_sender;
  localparam int AW    = 4;
  localparam int RW    = 16;
  localparam int BYTES = RW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_result_sender_if #(.ADDR_W(AW), .RES_W(RW)) bus_a ();
  matrix_result_sender_if #(.ADDR_W(AW), .RES_W(RW)) bus_b ();

  matrix_result_sender #(.N(2), .RES_W(RW), .ADDR_W(AW), .HEADER(8'hA5))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  matrix_result_sender #(.N(3), .RES_W(RW), .ADDR_W(AW), .HEADER(8'hA5))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // result memories, synchronous read
  logic [RW-1:0] mem_a [16];
  logic [RW-1:0] mem_b [16];
  always @(posedge clk) bus_a.res_data <= mem_a[bus_a.res_addr];
  always @(posedge clk) bus_b.res_data <= mem_b[bus_b.res_addr];

  // uart_tx models: busy for 10 cycles after each start, plus an external hold
  int   cnt_a = 0;
  int   cnt_b = 0;
  logic ext_a = 1'b0;
  logic ext_b = 1'b0;
  always @(posedge clk) begin
    if (bus_a.tx_start) cnt_a <= 10; else if (cnt_a > 0) cnt_a <= cnt_a - 1;
    if (bus_b.tx_start) cnt_b <= 10; else if (cnt_b > 0) cnt_b <= cnt_b - 1;
  end
  assign bus_a.tx_busy = (cnt_a != 0) || ext_a;
  assign bus_b.tx_busy = (cnt_b != 0) || ext_b;

  // frame model
  logic [7:0] exp_b [2][32];
  int exp_len [2];
  int pos     [2];
  int ts_cnt  [2];
  int done_cnt[2];
  int nn_of   [2];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected frame straight from the framing rules: header, MSB-first
  // bytes of every entry in row-major order, XOR of the data bytes.
  task automatic build_frame(input int id);
    logic [7:0]    cs;
    logic [7:0]    b;
    logic [RW-1:0] v;
    int            k;
    cs = 8'h00;
    k  = 0;
    exp_b[id][k] = 8'hA5;
    k++;
    for (int e = 0; e < nn_of[id] * nn_of[id]; e++) begin
      v = (id == 0) ? mem_a[e] : mem_b[e];
      for (int j = 0; j < BYTES; j++) begin
        b = 8'(v >> (8 * (BYTES - 1 - j)));
        exp_b[id][k] = b;
        k++;
        cs = cs ^ b;
      end
    end
    exp_b[id][k] = cs;
    k++;
    exp_len[id] = k;
    pos[id]     = 0;
  endtask

  task automatic mon(input int id, input logic ts, input logic [7:0] td, input logic tbz,
                     input logic [AW-1:0] ra, input logic bz, input logic dn);
    int ent;
    if (ts) begin
      ts_cnt[id]++;
      check($sformatf("i%0d_start_while_tx_busy", id), {31'd0, tbz}, 32'd0);
      check($sformatf("i%0d_busy_in_frame", id), {31'd0, bz}, 32'd1);
      if (pos[id] >= exp_len[id]) begin
        total++;
        bad++;
        $display("FAIL i%0d_extra_byte actual=%0h required=none", id, td);
      end else begin
        check($sformatf("i%0d_byte%0d", id, pos[id]), {24'd0, td}, {24'd0, exp_b[id][pos[id]]});
        if (pos[id] > 0) begin
          ent = (pos[id] == exp_len[id] - 1) ? nn_of[id] * nn_of[id] - 1 : (pos[id] - 1) / BYTES;
          check($sformatf("i%0d_res_addr_byte%0d", id, pos[id]), {28'd0, ra}, ent);
        end
        pos[id]++;
      end
    end
    if (dn) begin
      done_cnt[id]++;
      check($sformatf("i%0d_done_after_last", id), pos[id], exp_len[id]);
      check($sformatf("i%0d_busy_low_at_done", id), {31'd0, bz}, 32'd0);
    end
  endtask

  // single compare process
  always @(negedge clk) begin
    if (rst) begin
      pos[0] = 0;
      pos[1] = 0;
    end else begin
      mon(0, bus_a.tx_start, bus_a.tx_data, bus_a.tx_busy, bus_a.res_addr, bus_a.busy, bus_a.done);
      mon(1, bus_b.tx_start, bus_b.tx_data, bus_b.tx_busy, bus_b.res_addr, bus_b.busy, bus_b.done);
    end
  end

  task automatic pulse_start(input int id);
    @(negedge clk);
    if (id == 0) bus_a.start = 1'b1; else bus_b.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic wait_done(input int id, input string name);
    int d0;
    int c;
    d0 = done_cnt[id];
    c  = 0;
    while (done_cnt[id] == d0 && c < 3000) begin
      @(posedge clk);
      c++;
    end
    check({name, "_done_seen"}, {31'd0, done_cnt[id] != d0}, 32'd1);
  endtask

  task automatic wait_pos(input int id, input int target, input string name);
    int c;
    c = 0;
    while (pos[id] < target && c < 3000) begin
      @(posedge clk);
      c++;
    end
    check({name, "_reached_byte"}, {31'd0, pos[id] >= target}, 32'd1);
  endtask

  task automatic load_s1();
    mem_a[0] = 16'h0102;
    mem_a[1] = 16'h0304;
    mem_a[2] = 16'h0506;
    mem_a[3] = 16'h0708;
  endtask

  // run a full frame on instance a and check its counts afterwards
  task automatic full_frame_a(input string name);
    int t0;
    int d0;
    t0 = ts_cnt[0];
    d0 = done_cnt[0];
    pulse_start(0);
    wait_done(0, name);
    repeat (5) @(negedge clk);
    check({name, "_tx_starts"}, ts_cnt[0] - t0, 10);
    check({name, "_done_count"}, done_cnt[0] - d0, 1);
    check({name, "_busy_after"}, {31'd0, bus_a.busy}, 32'd0);
  endtask

  initial begin
    int t0;
    int d0;
    nn_of[0] = 2;
    nn_of[1] = 3;
    for (int i = 0; i < 2; i++) begin
      pos[i] = 0; ts_cnt[i] = 0; done_cnt[i] = 0; exp_len[i] = 0;
    end
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_res_addr", {28'd0, bus_a.res_addr}, 32'd0);
    check("rst_tx_data", {24'd0, bus_a.tx_data}, 32'd0);
    check("rst_tx_start", {31'd0, bus_a.tx_start}, 32'd0);
    check("rst_busy", {31'd0, bus_a.busy}, 32'd0);
    check("rst_done", {31'd0, bus_a.done}, 32'd0);
    check("rst_b_tx_data", {24'd0, bus_b.tx_data}, 32'd0);
    #1 rst = 1'b0;

    // 1: basic frame
    load_s1();
    build_frame(0);
    check("model_s1_len", exp_len[0], 10);
    check("model_s1_byte1", {24'd0, exp_b[0][1]}, 32'h01);
    check("model_s1_byte8", {24'd0, exp_b[0][8]}, 32'h08);
    check("model_s1_csum", {24'd0, exp_b[0][9]}, 32'h08);
    full_frame_a("s1");

    // 2: all ones -> checksum 0
    for (int i = 0; i < 4; i++) mem_a[i] = 16'hFFFF;
    build_frame(0);
    check("model_s2_byte5", {24'd0, exp_b[0][5]}, 32'hFF);
    check("model_s2_csum", {24'd0, exp_b[0][9]}, 32'h00);
    full_frame_a("s2");

    // 3: uart already busy for 50 cycles after start
    load_s1();
    build_frame(0);
    t0 = ts_cnt[0];
    d0 = done_cnt[0];
    @(negedge clk);
    ext_a = 1'b1;
    pulse_start(0);
    repeat (50) @(negedge clk);
    check("s3_no_start_while_held", ts_cnt[0] - t0, 0);
    check("s3_busy_while_held", {31'd0, bus_a.busy}, 32'd1);
    ext_a = 1'b0;
    wait_done(0, "s3");
    repeat (5) @(negedge clk);
    check("s3_tx_starts", ts_cnt[0] - t0, 10);
    check("s3_done_count", done_cnt[0] - d0, 1);

    // 4: second start mid-frame is ignored
    build_frame(0);
    t0 = ts_cnt[0];
    d0 = done_cnt[0];
    pulse_start(0);
    wait_pos(0, 4, "s4");
    pulse_start(0);
    wait_done(0, "s4");
    repeat (300) @(negedge clk);
    check("s4_tx_starts", ts_cnt[0] - t0, 10);
    check("s4_done_count", done_cnt[0] - d0, 1);
    check("s4_busy_after", {31'd0, bus_a.busy}, 32'd0);

    // 5: reset while draining byte 5
    build_frame(0);
    d0 = done_cnt[0];
    pulse_start(0);
    wait_pos(0, 5, "s5");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("s5_in_drain_tx_busy", {31'd0, bus_a.tx_busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("s5_async_tx_start", {31'd0, bus_a.tx_start}, 32'd0);
    check("s5_async_busy", {31'd0, bus_a.busy}, 32'd0);
    check("s5_async_res_addr", {28'd0, bus_a.res_addr}, 32'd0);
    check("s5_async_done", {31'd0, bus_a.done}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("s5_no_done_after_abort", done_cnt[0] - d0, 0);
    build_frame(0);
    full_frame_a("s5_restart");

    // 6: N=3, entries k*0x0101 -> 20 bytes, checksum 0
    for (int k = 0; k < 9; k++) mem_b[k] = 16'(k * 16'h0101);
    build_frame(1);
    check("model_s6_len", exp_len[1], 20);
    check("model_s6_byte17", {24'd0, exp_b[1][17]}, 32'h08);
    check("model_s6_csum", {24'd0, exp_b[1][19]}, 32'h00);
    t0 = ts_cnt[1];
    d0 = done_cnt[1];
    pulse_start(1);
    wait_done(1, "s6");
    repeat (5) @(negedge clk);
    check("s6_tx_starts", ts_cnt[1] - t0, 20);
    check("s6_done_count", done_cnt[1] - d0, 1);
    check("s6_res_addr_hold", {28'd0, bus_b.res_addr}, 32'd8);
    check("s6_busy_after", {31'd0, bus_b.busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/matrix_result_sender.md
Name: matrix_result_sender

Overview:
- Transmit-side framer for the matrix-multiplication datapath.
- After the multiplier finishes, it reads the N×N result matrix from result memory in row-major order and splits each entry into bytes, most significant byte first.
- It wraps the entries in a header byte and an XOR checksum and feeds the frame, one byte at a time, to uart_tx using uart_tx's start/busy handshake.
- It is the counterpart of the receive path that loads matrices A and B from uart_rx; it runs on the same clock as uart_tx.

Parameters:
- N, 3: matrix dimension; N*N entries are sent.
- RES_W, 16: result entry width in bits; must be a multiple of 8. BYTES = RES_W/8.
- ADDR_W, 4: result memory address width; 2**ADDR_W must be >= N*N.
- HEADER, 8'hA5: frame start byte.

Ports:
- clk  input  1  system clock; same clock as uart_tx.
- rst  input  1  reset; asynchronous and active-high.
- start  input  1  one-cycle pulse that begins a frame; ignored unless idle.
- res_addr  output  ADDR_W  result memory read address.
- res_data  input  RES_W  result memory read data; synchronous read, valid 1 cycle after res_addr changes.
- tx_data  output  8  byte to transmit; connects to uart_tx data.
- tx_start  output  1  one-cycle transmit request; connects to uart_tx start.
- tx_busy  input  1  uart_tx busy flag.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the checksum byte completes.

Behaviour:

Reset (asynchronous, rst=1):
- State returns to IDLE.
- res_addr=0, tx_data=0, tx_start=0, busy=0, done=0.
- Entry counter, byte index and checksum are cleared.
- Asserting rst mid-frame aborts the frame immediately; no done pulse is produced, and tx_start is low in the same cycle.

States:
- IDLE: busy=0. On start=1, go to HDR and clear the checksum to 0.
- HDR: load tx_data=HEADER. Go to SEND with kind=header.
- FETCH: drive res_addr=entry index. Go to CAPTURE next cycle (1-cycle read latency).
- CAPTURE: latch res_data into the shift register and set byte_idx=0. Go to LOAD.
- LOAD: set tx_data = byte byte_idx of the shift register, where index 0 is bits [RES_W-1:RES_W-8]. Set checksum ^= that byte. Go to SEND.
- SEND: wait while tx_busy=1. In the first cycle with tx_busy=0, assert tx_start for exactly that one cycle, then go to ACK.
- ACK: wait until tx_busy=1, then go to DRAIN. tx_data is held stable from LOAD/HDR through DRAIN.
- DRAIN: wait until tx_busy=0, then advance:
  - after the header byte → FETCH with entry=0;
  - after a data byte with byte_idx<BYTES-1 → increment byte_idx, go to LOAD;
  - after the last byte of an entry with entry<N*N-1 → increment entry, go to FETCH;
  - after the last byte of the last entry → set tx_data=checksum, go to SEND with kind=checksum;
  - after the checksum byte → DONE.
- DONE: done=1 for one cycle, busy drops, go to IDLE.

Frame and arithmetic rules:
- Frame length is 2 + N*N*BYTES bytes.
- The checksum is the 8-bit XOR of data bytes only; the header and the checksum byte itself are excluded.
- The entry counter and byte index never wrap. res_addr covers 0..N*N-1 only and holds its last value after the frame.

Boundary conditions:
- start while busy=1: ignored; the current frame is unaffected and no second frame is queued.
- start in the same cycle as done: ignored, because the block is not yet in IDLE.
- tx_busy already high at entry to SEND: tx_start stays low until tx_busy falls, so there is never a request while busy.
- tx_busy never rises after tx_start: the block stays in ACK. There is no timeout.

Test Plan:
1. N=2, RES_W=16, memory {0x0102,0x0304,0x0506,0x0708}, uart_tx model busy 10 cycles per byte, pulse start → tx bytes A5,01,02,03,04,05,06,07,08,08 (checksum 0x08); res_addr sequence 0,1,2,3; exactly 10 tx_start pulses; then one done pulse; busy=0 afterwards.
2. Same setup, memory all 0xFFFF → bytes A5, FF×8, 00; done once.
3. Hold tx_busy=1 for 50 cycles after start (external byte in flight) → no tx_start until tx_busy falls; then the normal frame follows.
4. Pulse start again in the middle of byte 4 → frame identical to scenario 1; only one done pulse.
5. Assert rst while waiting in DRAIN on byte 5 → tx_start=0, busy=0, res_addr=0 immediately with no clock edge; no done. A new start then produces a complete frame from header A5.
6. Default N=3, RES_W=16, entries 0..8 holding value k·0x0101 → 20 bytes; res_addr 0..8 in order; checksum equals 0x00, because each entry contributes two identical bytes.
